seg_scan_mux: RTL and testbench

//  Parametrised multiplexed 7-segment driver for the vending machine display.

---
 rtl/seg_scan_if.sv | 38 +++
 rtl/seg_scan_mux.sv | 253 +++++++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle of the data, control and display signals of the
// multiplexed 7-segment driver.
//   master : the side that supplies values and display controls (vending FSM / bench)
//   slave  : the display driver itself
// Signals
//   val      NUM_CH*VAL_W  binary values, channel c = val[c*VAL_W +: VAL_W]
//   load     1             one-cycle strobe: snapshot val and convert
//   ch_en    NUM_CH        per-channel visibility
//   blink    NUM_CH        per-channel blink request
//   seg_en   1             global display enable
//   busy     1             conversion in progress
//   done     1             one-cycle pulse on commit of new digits
//   seg_out  8             segments {dp,g,f,e,d,c,b,a}, active high
//   dig_out  2*NUM_CH      one-hot digit select, active high
interface seg_scan_if #(
  parameter int NUM_CH = 4,
  parameter int VAL_W  = 7
) ();
  logic [NUM_CH*VAL_W-1:0] val;
  logic                    load;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       blink;
  logic                    seg_en;
  logic                    busy;
  logic                    done;
  logic [7:0]              seg_out;
  logic [2*NUM_CH-1:0]     dig_out;

  modport master (
    output val, load, ch_en, blink, seg_en,
    input  busy, done, seg_out, dig_out
  );

  modport slave (
    input  val, load, ch_en, blink, seg_en,
    output busy, done, seg_out, dig_out
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed 7-segment driver for the vending machine display.
// Holds NUM_CH two-digit decimal fields. On a load strobe all channel values are
// snapshotted and converted one after the other by a single sequential
// double-dabble engine (one add-3/shift step per cycle); the new digits of all
// channels are committed together. A free-running prescaler scans the digits onto
// one-hot digit selects, with per-channel enable, blink, leading-zero blanking and
// an overflow marker ("-" for values >= 100).
// Ports
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : seg_scan_if.slave (val, load, ch_en, blink, seg_en in;
//          busy, done, seg_out, dig_out out -- all outputs registered)
module seg_scan_mux #(
  parameter int NUM_CH    = 4,
  parameter int VAL_W     = 7,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64,
  parameter int LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam int NUM_DIG = 2 * NUM_CH;
  localparam int DIG_W   = 8;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STEP_W  = $clog2(VAL_W);
  // At least two index bits so the channel part idx[IDX_W-1:1] is never empty.
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_DIG) : 2;
  localparam int PRE_W   = $clog2(SCAN_DIV);
  localparam int FRM_W   = $clog2(BLINK_DIV + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  // Double-dabble correction: a BCD nibble of 5 or more gets 3 added before the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Digit code to segment pattern {dp,g,f,e,d,c,b,a}; code F is the overflow dash.
  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h27;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h67;
      4'hF:    s = 8'h40;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Conversion state
  state_e                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [NUM_CH*VAL_W-1:0]     shadow_q, shadow_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [STEP_W-1:0]           step_q, step_d;
  logic [VAL_W-1:0]            bin_q, bin_d;
  logic [7:0]                  bcd_q, bcd_d;
  // pend holds finished channels of the running conversion; dig is what is displayed.
  logic [NUM_CH*DIG_W-1:0]     pend_q, pend_d;
  logic [NUM_CH*DIG_W-1:0]     dig_q, dig_d;

  // Scan state
  logic [PRE_W-1:0]            presc_q, presc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [FRM_W-1:0]            frame_q, frame_d;
  logic                        phase_q, phase_d;
  logic [7:0]                  seg_q, seg_d;
  logic [NUM_DIG-1:0]          digo_q, digo_d;

  // Combinational helpers
  logic [7:0]                  bcd_adj_s;
  logic [8+VAL_W-1:0]          shifted_s;
  logic [VAL_W-1:0]            cur_val_s;
  logic [7:0]                  conv_res_s;
  logic [CH_W-1:0]             ch_next_s;
  logic [IDX_W-2:0]            slot_ch_s;
  logic                        sel_en_s;
  logic                        sel_blink_s;
  logic [7:0]                  sel_dig_s;
  logic                        is_tens_s;
  logic [3:0]                  code_s;
  logic                        dark_s;

  // Conversion FSM: one add-3/shift step per cycle, channel by channel, atomic commit.
  always_comb begin
    state_d    = state_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    shadow_d   = shadow_q;
    ch_d       = ch_q;
    step_d     = step_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    pend_d     = pend_q;
    dig_d      = dig_q;

    bcd_adj_s  = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    shifted_s  = {bcd_adj_s, bin_q} << 1;
    cur_val_s  = shadow_q[int'(ch_q)*VAL_W +: VAL_W];
    // Overflow is decided from the binary value; the BCD path only covers 0..99.
    conv_res_s = (8'(cur_val_s) >= 8'd100) ? 8'hFF : shifted_s[8+VAL_W-1:VAL_W];
    ch_next_s  = ch_q + CH_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          shadow_d = bus.val;
          ch_d     = '0;
          step_d   = '0;
          bcd_d    = 8'h00;
          bin_d    = bus.val[VAL_W-1:0];
          busy_d   = 1'b1;
          state_d  = S_CONV;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CONV: begin
        if (step_q == STEP_W'(VAL_W - 1)) begin
          pend_d[int'(ch_q)*DIG_W +: DIG_W] = conv_res_s;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            dig_d   = pend_d;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_next_s;
            step_d  = '0;
            bcd_d   = 8'h00;
            bin_d   = shadow_q[int'(ch_next_s)*VAL_W +: VAL_W];
            busy_d  = 1'b1;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
          bcd_d  = shifted_s[8+VAL_W-1:VAL_W];
          bin_d  = shifted_s[VAL_W-1:0];
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan timing: prescaler -> digit index -> frame count -> blink phase.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IDX_W'(NUM_DIG - 1)) begin
        idx_d = '0;
        if (frame_q == FRM_W'(BLINK_DIV - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FRM_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  // Display output for the current slot; registered so pins change one cycle later.
  always_comb begin
    slot_ch_s   = idx_q[IDX_W-1:1];
    sel_en_s    = bus.ch_en[slot_ch_s];
    sel_blink_s = bus.blink[slot_ch_s];
    sel_dig_s   = dig_q[int'(slot_ch_s)*DIG_W +: DIG_W];
    is_tens_s   = ~idx_q[0];
    code_s      = is_tens_s ? sel_dig_s[7:4] : sel_dig_s[3:0];
    dark_s      = ~bus.seg_en | ~sel_en_s | (sel_blink_s & phase_q);
    seg_d       = 8'h00;
    digo_d      = '0;
    if (dark_s) begin
      seg_d  = 8'h00;
      digo_d = '0;
    end else begin
      digo_d = {{(NUM_DIG-1){1'b0}}, 1'b1} << idx_q;
      // A blanked leading zero keeps its digit select so the scan duty stays even.
      if ((LZ_BLANK != 0) && is_tens_s && (code_s == 4'h0)) begin
        seg_d = 8'h00;
      end else begin
        seg_d = seg_decode(code_s);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      ch_q     <= '0;
      step_q   <= '0;
      bin_q    <= '0;
      bcd_q    <= 8'h00;
      pend_q   <= '0;
      dig_q    <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      seg_q    <= 8'h00;
      digo_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      ch_q     <= ch_d;
      step_q   <= step_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      pend_q   <= pend_d;
      dig_q    <= dig_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      digo_q   <= digo_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.seg_out = seg_q;
  assign bus.dig_out = digo_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (NUM_CH=4, VAL_W=7, SCAN_DIV=4, BLINK_DIV=2).
// A cycle-level reference model derives the expected outputs from the cycle count
// since reset and decimal arithmetic; directed table vectors and hand sequences
// cover conversion, overflow, load-ignore, scan order, blink/enable and reset abort.
module tb_seg_scan_mux;
  localparam int NUM_CH    = 4;
  localparam int VAL_W     = 7;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int NUM_DIG   = 8;
  localparam int CONV_CYC  = NUM_CH * VAL_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) bus ();

  seg_scan_mux #(
    .NUM_CH(NUM_CH), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV),
    .BLINK_DIV(BLINK_DIV), .LZ_BLANK(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_k;
  int         m_busy;
  int         m_cnt;
  int         m_shadow[NUM_CH];
  int         m_tens[NUM_CH];
  int         m_units[NUM_CH];
  logic       m_done;
  logic [7:0] m_seg;
  logic [7:0] m_dig;

  typedef struct {
    string       name;
    logic [27:0] val;
    logic [63:0] exp;   // byte j = seg_out shown in slot j
  } vec_t;
  vec_t vecs[4];

  function automatic logic [7:0] lut(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h27;
      8: return 8'h7F;  9: return 8'h67;  15: return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [27:0] pack4(input int v3, input int v2, input int v1, input int v0);
    return {7'(v3), 7'(v2), 7'(v1), 7'(v0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock: predict from pre-edge state, then compare after the edge.
  task automatic tick();
    int   slot, c, ph, d, v;
    logic dark;
    if (rst) begin
      m_k = 0; m_busy = 0; m_cnt = 0; m_done = 1'b0; m_seg = 8'h00; m_dig = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        m_tens[i] = 0; m_units[i] = 0;
      end
    end else begin
      slot = (m_k / SCAN_DIV) % NUM_DIG;
      c    = slot / 2;
      ph   = ((m_k / (SCAN_DIV * NUM_DIG)) / BLINK_DIV) % 2;
      d    = (slot % 2 == 0) ? m_tens[c] : m_units[c];
      dark = !bus.seg_en || !bus.ch_en[c] || (bus.blink[c] && ph == 1);
      if (dark) begin
        m_seg = 8'h00; m_dig = 8'h00;
      end else begin
        m_dig = 8'h01 << slot;
        m_seg = (slot % 2 == 0 && d == 0) ? 8'h00 : lut(d);
      end
      m_done = 1'b0;
      if (m_busy != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          for (int i = 0; i < NUM_CH; i++) begin
            v = m_shadow[i];
            if (v >= 100) begin
              m_tens[i] = 15; m_units[i] = 15;
            end else begin
              m_tens[i] = v / 10; m_units[i] = v % 10;
            end
          end
          m_done = 1'b1;
          m_busy = 0;
        end
      end else if (bus.load) begin
        for (int i = 0; i < NUM_CH; i++) m_shadow[i] = int'(bus.val[i*VAL_W +: VAL_W]);
        m_busy = 1;
        m_cnt  = CONV_CYC;
      end
      m_k++;
    end
    @(posedge clk);
    #1;
    chk("model_busy", bus.busy, m_busy[0]);
    chk("model_done", bus.done, m_done);
    chk("model_seg", bus.seg_out, m_seg);
    chk("model_dig", bus.dig_out, m_dig);
  endtask

  task automatic pulse_load();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  // Wait (bounded) for done; returns number of busy cycles seen including the current one.
  task automatic wait_done(input string name, output int busy_cnt);
    bit seen = 0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1;
      else if (bus.busy) busy_cnt++;
    end
    chk({name, "_done_seen"}, seen, 1'b1);
  endtask

  // Record the segment pattern of every digit slot over (at most) three frames.
  task automatic capture_frame(input string name, output logic [63:0] segs);
    logic [7:0] seen = 8'h00;
    segs = '0;
    for (int i = 0; i < 3 * NUM_DIG * SCAN_DIV && seen != 8'hFF; i++) begin
      tick();
      for (int j = 0; j < NUM_DIG; j++) begin
        if (bus.dig_out == (8'h01 << j)) begin
          segs[j*8 +: 8] = bus.seg_out;
          seen[j] = 1'b1;
        end
      end
    end
    chk({name, "_all_slots"}, seen, 8'hFF);
  endtask

  initial begin
    logic [63:0] segs;
    logic [7:0]  prev;
    int          bc, run, ndone, ch1_hits, ch2_hits;
    bit          first;

    vecs[0] = '{"t2_99_42_7_0",     pack4(99, 42, 7, 0),    64'h67675B6627003F00};
    vecs[1] = '{"ovf_127_100_10_5", pack4(127, 100, 10, 5), 64'h404040403F066D00};
    vecs[2] = '{"v_50_8_61_33",     pack4(50, 8, 61, 33),   64'h3F6D7F00067D4F4F};
    vecs[3] = '{"v_1_90_19_84",     pack4(1, 90, 19, 84),   64'h06003F676706667F};

    rst = 1'b1;
    bus.val = '0; bus.load = 1'b0; bus.ch_en = 4'h0; bus.blink = 4'h0; bus.seg_en = 1'b0;

    // T1: reset
    tick(); tick();
    rst = 1'b0;
    chk("t1_busy", bus.busy, 1'b0);
    chk("t1_done", bus.done, 1'b0);
    chk("t1_seg", bus.seg_out, 8'h00);
    chk("t1_dig", bus.dig_out, 8'h00);
    bus.ch_en = 4'hF; bus.seg_en = 1'b1;
    capture_frame("t1", segs);
    chk("t1_frame", segs, 64'h3F003F003F003F00);

    // T2 + table: conversion latency and displayed digits
    for (int n = 0; n < 4; n++) begin
      bus.val = vecs[n].val;
      pulse_load();
      wait_done(vecs[n].name, bc);
      chk({vecs[n].name, "_busy_len"}, bc, CONV_CYC);
      tick();
      chk({vecs[n].name, "_done_1cyc"}, bus.done, 1'b0);
      capture_frame(vecs[n].name, segs);
      chk({vecs[n].name, "_frame"}, segs, vecs[n].exp);
    end

    // T3: overflow, load ignored while busy, later load accepted
    bus.val = pack4(0, 0, 0, 127);
    pulse_load();
    for (int i = 0; i < 4; i++) tick();
    bus.val = pack4(0, 0, 0, 3);
    pulse_load();
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("t3_single_done", ndone, 1);
    capture_frame("t3a", segs);
    chk("t3_ovf_ch0", segs[15:0], 16'h4040);
    pulse_load();
    wait_done("t3b", bc);
    capture_frame("t3b", segs);
    chk("t3_reload_ch0", segs[15:0], 16'h4F00);

    // T4: scan order and dwell, then display dark while the scan continues
    prev = bus.dig_out; run = 0; first = 1;
    for (int i = 0; i < 44; i++) begin
      tick();
      run++;
      if (bus.dig_out !== prev) begin
        if (!first) begin
          chk("t4_dwell", run, SCAN_DIV);
          chk("t4_order", bus.dig_out, {prev[6:0], prev[7]});
        end
        first = 0; prev = bus.dig_out; run = 0;
      end
    end
    bus.seg_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_dark_dig", bus.dig_out, 8'h00);
    end
    bus.seg_en = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // T5: blink on ch1, ch2 disabled
    bus.blink = 4'b0010; bus.ch_en = 4'b1011;
    ch1_hits = 0; ch2_hits = 0;
    for (int i = 0; i < 5 * NUM_DIG * SCAN_DIV; i++) begin
      tick();
      if (bus.dig_out[3:2] != 2'b00) ch1_hits++;
      if (bus.dig_out[5:4] != 2'b00) ch2_hits++;
    end
    chk("t5_ch2_dark", ch2_hits, 0);
    chk("t5_ch1_blinks", (ch1_hits > 0) && (ch1_hits < 40), 1'b1);
    bus.blink = 4'h0; bus.ch_en = 4'hF;

    // T6: reset in the middle of a conversion
    bus.val = pack4(55, 66, 77, 88);
    pulse_load();
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", bus.busy, 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    capture_frame("t6", segs);
    chk("t6_cleared", segs, 64'h3F003F003F003F00);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus.load   = ($urandom_range(0, 7) == 0);
      bus.val    = 28'($urandom);
      bus.ch_en  = 4'($urandom);
      bus.blink  = 4'($urandom);
      bus.seg_en = ($urandom_range(0, 5) != 0);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; bus.load = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
